// File: rtl/data_bus_pkg.sv
// Shared constants for the data-side responder: register map, status bit layout
// and the address-region select used by the decoder.
package data_bus_pkg;

    localparam logic [31:0] CONSOLE_DATA_ADDR   = 32'h8000_0000;
    localparam logic [31:0] CONSOLE_STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_COUNT_ADDR    = 32'h8000_0008;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_COUNT_LSB    = 8;
    localparam int STATUS_COUNT_W      = 8;

    typedef enum logic [2:0] {
        RAM,
        CONSOLE_DATA,
        CONSOLE_STATUS,
        CYCLE_COUNT,
        NONE
    } region_e;

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console sink through a valid/ready handshake.
// A push into a full FIFO is still accepted when the head leaves in the same cycle.
module console_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_ready,
    output logic                     valid,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign valid         = (count_q != '0);
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign count         = count_q;
    assign pop           = valid && pop_ready;
    assign push_accepted = push && (!full || pop);
    // Gating keeps the head at zero after reset, since the storage is not cleared.
    assign head          = valid ? mem_q[rd_ptr_q] : 8'h00;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_accepted) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_accepted, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_accepted) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder for the single-cycle core: word RAM, console FIFO and cycle counter.
// Define DATA_BUS_RESPONDER_CYCLE_COUNTER_EN to build the CYCLE_COUNT register.
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    region_e          region;
    logic [31:0]      ram_q [RAM_WORDS];
    logic             overflow_q, overflow_d;
    logic             fifo_push, fifo_accepted, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word;
    logic [31:0]      cycle_value;

    // The low two address bits are ignored everywhere: only word accesses exist.
    always_comb begin
        region = NONE;
        if (address[31:RAM_AW+2] == '0) begin
            region = RAM;
        end else if (address[31:2] == CONSOLE_DATA_ADDR[31:2]) begin
            region = CONSOLE_DATA;
        end else if (address[31:2] == CONSOLE_STATUS_ADDR[31:2]) begin
            region = CONSOLE_STATUS;
        end else if (address[31:2] == CYCLE_COUNT_ADDR[31:2]) begin
            region = CYCLE_COUNT;
        end
    end

    always_ff @(posedge clock) begin
        if (memory_write && (region == RAM)) begin
            ram_q[address[RAM_AW+1:2]] <= write_data;
        end
    end

    assign fifo_push = memory_write && (region == CONSOLE_DATA);

    console_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_console_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (fifo_push),
        .push_data    (write_data[7:0]),
        .pop_ready    (console_ready),
        .valid        (console_valid),
        .head         (console_data),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .push_accepted(fifo_accepted)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (fifo_push && !fifo_accepted) begin
            overflow_d = 1'b1;
        end else if (memory_write && (region == CONSOLE_STATUS)) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    // A software load wins over the free-running increment.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (memory_write && (region == CYCLE_COUNT)) begin
            cycle_d = write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_value = cycle_q;
`else
    assign cycle_value = 32'h0000_0000;
`endif

    always_comb begin
        status_word                                       = '0;
        status_word[STATUS_FULL_BIT]                      = fifo_full;
        status_word[STATUS_EMPTY_BIT]                     = fifo_empty;
        status_word[STATUS_OVERFLOW_BIT]                  = overflow_q;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W]   = STATUS_COUNT_W'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        case (region)
            RAM:            read_data = ram_q[address[RAM_AW+1:2]];
            CONSOLE_STATUS: read_data = status_word;
            CYCLE_COUNT:    read_data = cycle_value;
            default:        read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: table-driven bus vectors plus hand sequences for the
// console FIFO, counter and asynchronous reset, with a byte scoreboard on the console port.
module tb_data_bus_responder;

    localparam int DEPTH = 4;
    localparam logic [31:0] A_CDATA  = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_NONE   = 32'h8000_0010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memory_write = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        console_ready = 1'b0;
    logic [31:0] read_data;
    logic        console_valid;
    logic [7:0]  console_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc = 32'h0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    data_bus_responder #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .memory_write (memory_write),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .console_valid(console_valid),
        .console_data (console_data),
        .console_ready(console_ready)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cycle();
`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
        return m_cyc;
`else
        return 32'h0;
`endif
    endfunction

    // One bus cycle: drive, check combinational outputs before the edge, advance the model.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rdy, input logic chk, input logic [31:0] exp,
                         input string name);
        logic       pop;
        logic       full_before;
        logic [7:0] popped;
        memory_write  = we;
        address       = addr;
        write_data    = wdata;
        console_ready = rdy;
        #1;
        if (chk) check32(name, read_data, exp);
        check32("console_valid", {31'b0, console_valid}, {31'b0, exp_q.size() != 0});
        full_before = (exp_q.size() == DEPTH);
        pop = (exp_q.size() != 0) && rdy;
        if (exp_q.size() != 0) check32("console_data", {24'b0, console_data}, {24'b0, exp_q[0]});
        if (pop) popped = exp_q.pop_front();
        if (we && addr[31:2] == A_CDATA[31:2]) begin
            if (!full_before || pop) exp_q.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
        end
        if (we && addr[31:2] == A_STATUS[31:2]) m_ovf = 1'b0;
        m_cyc = (we && addr[31:2] == A_CYCLE[31:2]) ? wdata : m_cyc + 32'd1;
        @(posedge clock);
        #1;
        memory_write = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_0F0F, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0001, 32'h0,         32'h1234_5678};
        vecs[6]  = '{1'b0, 32'h0000_00FE, 32'h0,         32'hA5A5_0F0F};
        vecs[7]  = '{1'b1, 32'h0000_0110, 32'h1111_1111, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h0000_0110, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 32'h4000_0010, 32'h0,         32'h0};
        vecs[11] = '{1'b0, A_CDATA,       32'h0,         32'h0};

        // Reset values while reset is held
        #1;
        check32("reset_valid", {31'b0, console_valid}, 32'h0);
        check32("reset_data", {24'b0, console_data}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_cyc = 32'h0;
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, 32'h0, "cycle_at_0");
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0002, "status_reset");
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, exp_cycle(), "cycle_at_2");

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, !vecs[i].we, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, exp_cycle(), "cycle_index");

        // Handshake: two bytes queue up, then drain on back-to-back cycles
        drive(1'b1, A_CDATA, 32'h0000_0041, 1'b0, 1'b0, 32'h0, "");
        drive(1'b1, A_CDATA, 32'hFFFF_FF42, 1'b0, 1'b0, 32'h0, "");
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0200, "status_two");
        drive(1'b0, A_NONE, 32'h0, 1'b1, 1'b0, 32'h0, "");
        drive(1'b0, A_NONE, 32'h0, 1'b1, 1'b0, 32'h0, "");
        drive(1'b0, A_STATUS, 32'h0, 1'b1, 1'b1, 32'h0000_0002, "status_drained");

        // Overflow: five pushes into four entries
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, A_CDATA, 32'h61 + i, 1'b0, 1'b0, 32'h0, "");
        end
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0405, "status_overflow");
        drive(1'b1, A_STATUS, 32'h1234_5678, 1'b0, 1'b0, 32'h0, "");
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0401, "status_ovf_clr");

        // Full FIFO with push and pop in the same cycle
        drive(1'b1, A_CDATA, 32'h0000_0055, 1'b1, 1'b0, 32'h0, "");
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0401, "status_full_pp");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, A_NONE, 32'h0, 1'b1, 1'b0, 32'h0, "");
        end
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0002, "status_empty");

        // Counter load and wrap
        drive(1'b1, A_CYCLE, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, "");
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, exp_cycle(), "cycle_loaded");
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, exp_cycle(), "cycle_wrapped");

        // Asynchronous reset between edges with two bytes pending
        drive(1'b1, A_CDATA, 32'h0000_0071, 1'b0, 1'b0, 32'h0, "");
        drive(1'b1, A_CDATA, 32'h0000_0072, 1'b0, 1'b0, 32'h0, "");
        check32("pre_reset_valid", {31'b0, console_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check32("async_reset_valid", {31'b0, console_valid}, 32'h0);
        check32("async_reset_data", {24'b0, console_data}, 32'h0);
        exp_q.delete();
        m_ovf = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_cyc = 32'h0;
        drive(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 32'h0000_0002, "status_after_reset");
        drive(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1, exp_cycle(), "cycle_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
